// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ARM-subset control path decoding in D and carrying conditional control through E/M/W.
// Holds NZCV and gates every state-changing bit of the E-stage instruction with its condition result.
module pipelined_control_unit #(
    parameter int ALUCTRL_W    = 2,
    parameter bit EARLY_BRANCH = 1
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [31:0]          InstrD,
    input  logic                 FlushE,
    input  logic [3:0]           ALUFlagsE,
    output logic [1:0]           ImmSrcD,
    output logic [1:0]           RegSrcD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchTakenE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 MemtoRegE,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW,
    output logic [3:0]           FlagsQ
);
    localparam bit EXT = ALUCTRL_W >= 3;

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [2:0] w_dp_alu;
    logic       w_dp_valid, w_dp_logic, w_dp_cmp;
    logic       w_regw_d, w_memw_d, w_memtoreg_d, w_alusrc_d, w_branch_d, w_pcs_d;
    logic [2:0] w_alu_d;
    logic [1:0] w_flagw_d;
    logic       w_n, w_z, w_c, w_v, w_condex;
    logic       w_unused;

    logic                 r_regw_e, r_memw_e, r_memtoreg_e, r_alusrc_e, r_branch_e, r_pcs_e;
    logic [ALUCTRL_W-1:0] r_alu_e;
    logic [1:0]           r_flagw_e;
    logic [3:0]           r_cond_e;
    logic                 r_regw_m, r_memw_m, r_memtoreg_m, r_pcs_m;
    logic                 r_regw_w, r_memtoreg_w, r_pcs_w;
    logic [3:0]           r_flags;

    assign w_op     = InstrD[27:26];
    assign w_cmd    = InstrD[24:21];
    assign w_s      = InstrD[20];
    assign w_unused = ^{InstrD[19:16], InstrD[11:0]};

    // Extended commands only exist when the ALU bus is wide enough to name them.
    always_comb begin
        w_dp_alu   = 3'd0;
        w_dp_valid = 1'b0;
        w_dp_logic = 1'b0;
        w_dp_cmp   = 1'b0;
        case (w_cmd)
            4'b0100: w_dp_valid = 1'b1;
            4'b0010: begin w_dp_alu = 3'd1; w_dp_valid = 1'b1; end
            4'b0000: begin w_dp_alu = 3'd2; w_dp_valid = 1'b1; w_dp_logic = 1'b1; end
            4'b1100: begin w_dp_alu = 3'd3; w_dp_valid = 1'b1; w_dp_logic = 1'b1; end
            4'b0001: if (EXT) begin w_dp_alu = 3'd4; w_dp_valid = 1'b1; w_dp_logic = 1'b1; end
            4'b1101: if (EXT) begin w_dp_alu = 3'd5; w_dp_valid = 1'b1; w_dp_logic = 1'b1; end
            4'b1010: if (EXT) begin w_dp_alu = 3'd1; w_dp_valid = 1'b1; w_dp_cmp = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        ImmSrcD      = 2'b00;
        RegSrcD      = 2'b00;
        w_regw_d     = 1'b0;
        w_memw_d     = 1'b0;
        w_memtoreg_d = 1'b0;
        w_alusrc_d   = 1'b0;
        w_alu_d      = 3'd0;
        w_flagw_d    = 2'b00;
        w_branch_d   = 1'b0;
        case (w_op)
            2'b00: begin
                w_alusrc_d = InstrD[25];
                w_alu_d    = w_dp_alu;
                w_regw_d   = w_dp_valid & ~w_dp_cmp;
                w_flagw_d  = w_dp_cmp ? 2'b11 : (w_dp_valid & w_s) ? (w_dp_logic ? 2'b10 : 2'b11) : 2'b00;
            end
            2'b01: begin
                ImmSrcD      = 2'b01;
                w_alusrc_d   = 1'b1;
                w_regw_d     = w_s;
                w_memtoreg_d = w_s;
                w_memw_d     = ~w_s;
                RegSrcD      = w_s ? 2'b00 : 2'b10;
            end
            2'b10: begin
                ImmSrcD    = 2'b10;
                RegSrcD    = 2'b01;
                w_alusrc_d = 1'b1;
                w_branch_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_pcs_d = ((InstrD[15:12] == 4'hF) & w_regw_d) | (w_branch_d & ~EARLY_BRANCH);

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_condex = 1'b0;
        case (r_cond_e)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = w_n == w_v;
            4'b1011: w_condex = w_n != w_v;
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            {r_regw_e, r_memw_e, r_memtoreg_e, r_alusrc_e, r_branch_e, r_pcs_e} <= '0;
            r_alu_e      <= '0;
            r_flagw_e    <= '0;
            r_cond_e     <= '0;
            {r_regw_m, r_memw_m, r_memtoreg_m, r_pcs_m} <= '0;
            {r_regw_w, r_memtoreg_w, r_pcs_w} <= '0;
            r_flags      <= '0;
        end else begin
            if (FlushE) begin
                {r_regw_e, r_memw_e, r_memtoreg_e, r_alusrc_e, r_branch_e, r_pcs_e} <= '0;
                r_alu_e   <= '0;
                r_flagw_e <= '0;
                r_cond_e  <= '0;
            end else begin
                {r_regw_e, r_memw_e, r_memtoreg_e, r_alusrc_e, r_branch_e, r_pcs_e} <=
                    {w_regw_d, w_memw_d, w_memtoreg_d, w_alusrc_d, w_branch_d, w_pcs_d};
                r_alu_e   <= ALUCTRL_W'(w_alu_d);
                r_flagw_e <= w_flagw_d;
                r_cond_e  <= InstrD[31:28];
            end
            if (r_flagw_e[1] & w_condex) r_flags[3:2] <= ALUFlagsE[3:2];
            if (r_flagw_e[0] & w_condex) r_flags[1:0] <= ALUFlagsE[1:0];
            r_regw_m     <= r_regw_e & w_condex;
            r_memw_m     <= r_memw_e & w_condex;
            r_memtoreg_m <= r_memtoreg_e;
            r_pcs_m      <= r_pcs_e & w_condex;
            r_regw_w     <= r_regw_m;
            r_memtoreg_w <= r_memtoreg_m;
            r_pcs_w      <= r_pcs_m;
        end
    end

    assign ALUSrcE      = r_alusrc_e;
    assign ALUControlE  = r_alu_e;
    assign MemtoRegE    = r_memtoreg_e;
    assign BranchTakenE = r_branch_e & w_condex & EARLY_BRANCH;
    assign MemWriteM    = r_memw_m;
    assign RegWriteM    = r_regw_m;
    assign RegWriteW    = r_regw_w;
    assign MemtoRegW    = r_memtoreg_w;
    assign PCSrcW       = r_pcs_w;
    assign FlagsQ       = r_flags;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: scoreboard bench comparing two configurations against an instruction-level model.
module tb_pipelined_control_unit;
    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [31:0] InstrD = 32'hE2811001;
    logic        FlushE = 1'b0;
    logic [3:0]  ALUFlagsE = 4'h0;

    logic [1:0] imm0, rsrc0, imm1, rsrc1;
    logic [1:0] alu0;
    logic [2:0] alu1;
    logic [3:0] flags0, flags1;
    logic alusrc0, bt0, memwm0, regwm0, memtoe0, regww0, memtow0, pcsw0;
    logic alusrc1, bt1, memwm1, regwm1, memtoe1, regww1, memtow1, pcsw1;

    pipelined_control_unit #(.ALUCTRL_W(2), .EARLY_BRANCH(1)) u0 (
        .CLK(CLK), .RESETn(RESETn), .InstrD(InstrD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
        .ImmSrcD(imm0), .RegSrcD(rsrc0), .ALUSrcE(alusrc0), .ALUControlE(alu0),
        .BranchTakenE(bt0), .MemWriteM(memwm0), .RegWriteM(regwm0), .MemtoRegE(memtoe0),
        .RegWriteW(regww0), .MemtoRegW(memtow0), .PCSrcW(pcsw0), .FlagsQ(flags0));

    pipelined_control_unit #(.ALUCTRL_W(3), .EARLY_BRANCH(0)) u1 (
        .CLK(CLK), .RESETn(RESETn), .InstrD(InstrD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
        .ImmSrcD(imm1), .RegSrcD(rsrc1), .ALUSrcE(alusrc1), .ALUControlE(alu1),
        .BranchTakenE(bt1), .MemWriteM(memwm1), .RegWriteM(regwm1), .MemtoRegE(memtoe1),
        .RegWriteW(regww1), .MemtoRegW(memtow1), .PCSrcW(pcsw1), .FlagsQ(flags1));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] imm, rsrc;
        logic       regw, memw, memtoreg, alusrc;
        logic [2:0] alu;
        logic [1:0] flagw;
        logic       branch, pcs;
        logic [3:0] cond;
    } ctl_t;

    typedef struct packed {
        logic regw, memw, memtoreg, pcs;
    } late_t;

    typedef struct packed {
        logic [1:0] imm, rsrc;
        logic       alusrc;
        logic [2:0] alu;
        logic       bt, memwm, regwm, memtoe, regww, memtow, pcsw;
        logic [3:0] flags;
    } obs_t;

    ctl_t  e_st[2];
    late_t m_st[2], w_st[2];
    logic [3:0] fl[2];
    obs_t sb0[$], sb1[$];
    int checks = 0, failures = 0, cyc = 0;

    localparam logic [31:0] ADD   = 32'hE2811001, SUBS = 32'hE0512002, ADDEQ = 32'h02811001;
    localparam logic [31:0] ADDNE = 32'h12811001, BEQ  = 32'h0A000002, STR   = 32'hE5812000;
    localparam logic [31:0] CMP   = 32'hE1510002, EOR  = 32'hE0212003, MOVPC = 32'hF1A0F001;
    localparam logic [31:0] LDR   = 32'hE5912000, NOP  = 32'hEC000000;

    // ARM conditions come in complementary pairs; bit 0 inverts the even member.
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = f[3] == f[0];
            3'd6: r = !f[2] && (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic ctl_t decode(logic [31:0] i, bit ext, bit eb);
        ctl_t d;
        logic [3:0] cmd;
        bit ok, lg, cmp;
        d = '0;
        d.cond = i[31:28];
        cmd = i[24:21];
        ok = 1; lg = 0; cmp = 0;
        case (i[27:26])
            2'd0: begin
                d.alusrc = i[25];
                if (cmd == 4'h4) d.alu = 0;
                else if (cmd == 4'h2) d.alu = 1;
                else if (cmd == 4'h0) begin d.alu = 2; lg = 1; end
                else if (cmd == 4'hC) begin d.alu = 3; lg = 1; end
                else if (ext && cmd == 4'h1) begin d.alu = 4; lg = 1; end
                else if (ext && cmd == 4'hD) begin d.alu = 5; lg = 1; end
                else if (ext && cmd == 4'hA) begin d.alu = 1; cmp = 1; end
                else ok = 0;
                d.regw = ok && !cmp;
                if (cmp) d.flagw = 2'b11;
                else if (ok && i[20]) d.flagw = lg ? 2'b10 : 2'b11;
            end
            2'd1: begin
                d.imm = 2'b01;
                d.alusrc = 1;
                if (i[20]) begin d.regw = 1; d.memtoreg = 1; end
                else begin d.memw = 1; d.rsrc = 2'b10; end
            end
            2'd2: begin
                d.imm = 2'b10;
                d.rsrc = 2'b01;
                d.alusrc = 1;
                d.branch = 1;
            end
            default: ;
        endcase
        d.pcs = (i[15:12] == 4'hF && d.regw) || (d.branch && !eb);
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_st[k] = '0; m_st[k] = '0; w_st[k] = '0; fl[k] = '0;
        end
    endtask

    // Drive one cycle's inputs at a falling edge and queue what each DUT must show after the next rising edge.
    task automatic step(logic [31:0] ins, bit fsh, logic [3:0] af);
        InstrD = ins; FlushE = fsh; ALUFlagsE = af;
        for (int k = 0; k < 2; k++) begin
            bit p, ext, eb;
            ctl_t d;
            obs_t o;
            ext = (k == 1); eb = (k == 0);
            p = cond_ok(e_st[k].cond, fl[k]);
            if (e_st[k].flagw[1] && p) fl[k][3:2] = af[3:2];
            if (e_st[k].flagw[0] && p) fl[k][1:0] = af[1:0];
            w_st[k] = m_st[k];
            m_st[k] = '{regw: e_st[k].regw & p, memw: e_st[k].memw & p,
                        memtoreg: e_st[k].memtoreg, pcs: e_st[k].pcs & p};
            d = decode(ins, ext, eb);
            e_st[k] = fsh ? '0 : d;
            o.imm = d.imm; o.rsrc = d.rsrc;
            o.alusrc = e_st[k].alusrc; o.alu = e_st[k].alu;
            o.bt = e_st[k].branch && cond_ok(e_st[k].cond, fl[k]) && eb;
            o.memwm = m_st[k].memw; o.regwm = m_st[k].regw; o.memtoe = e_st[k].memtoreg;
            o.regww = w_st[k].regw; o.memtow = w_st[k].memtoreg; o.pcsw = w_st[k].pcs;
            o.flags = fl[k];
            if (k == 0) sb0.push_back(o); else sb1.push_back(o);
        end
        @(negedge CLK);
    endtask

    always @(posedge CLK) begin
        obs_t a, x;
        #1;
        cyc++;
        if (sb0.size() > 0) begin
            x = sb0.pop_front();
            a = {imm0, rsrc0, alusrc0, 1'b0, alu0, bt0, memwm0, regwm0, memtoe0, regww0, memtow0, pcsw0, flags0};
            checks++;
            if (a !== x) begin
                failures++;
                $display("FAIL dut0 cyc %0d: got %h expected %h", cyc, a, x);
            end
        end
        if (sb1.size() > 0) begin
            x = sb1.pop_front();
            a = {imm1, rsrc1, alusrc1, alu1, bt1, memwm1, regwm1, memtoe1, regww1, memtow1, pcsw1, flags1};
            checks++;
            if (a !== x) begin
                failures++;
                $display("FAIL dut1 cyc %0d: got %h expected %h", cyc, a, x);
            end
        end
    end

    task automatic rst_check(string tag);
        logic [15:0] r0, r1;
        r0 = {alusrc0, 1'b0, alu0, bt0, memwm0, regwm0, memtoe0, regww0, memtow0, pcsw0, flags0};
        r1 = {alusrc1, alu1, bt1, memwm1, regwm1, memtoe1, regww1, memtow1, pcsw1, flags1};
        checks++;
        if (r0 !== 16'h0) begin failures++; $display("FAIL %s dut0: got %h expected 0000", tag, r0); end
        checks++;
        if (r1 !== 16'h0) begin failures++; $display("FAIL %s dut1: got %h expected 0000", tag, r1); end
    endtask

    // Reset strikes between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset(string tag);
        @(posedge CLK);
        #3 RESETn = 1'b0;
        #1 rst_check(tag);
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        int sel;
        i = $urandom();
        sel = $urandom_range(0, 9);
        i[27:26] = (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
        if ($urandom_range(0, 3) == 0) i[15:12] = 4'hF;
        if ($urandom_range(0, 2) == 0) i[31:28] = 4'hE;
        return i;
    endfunction

    initial begin
        model_reset();
        #2 rst_check("reset");
        InstrD = LDR;
        #1;
        checks++;
        if ({imm0, rsrc0, imm1, rsrc1} !== 8'b01000100) begin
            failures++;
            $display("FAIL d_in_reset: got %b expected 01000100", {imm0, rsrc0, imm1, rsrc1});
        end
        InstrD = ADD;
        @(negedge CLK);
        RESETn = 1'b1;
        step(ADD,   0, 4'h0);
        step(NOP,   0, 4'h0);
        step(SUBS,  0, 4'h0);
        step(ADDEQ, 0, 4'b0100);
        step(ADDNE, 0, 4'b1111);
        step(BEQ,   0, 4'h0);
        step(NOP,   0, 4'h0);
        step(SUBS,  0, 4'h0);
        step(BEQ,   0, 4'b0000);
        step(NOP,   0, 4'h0);
        step(STR,   1, 4'h0);
        step(CMP,   0, 4'h0);
        step(EOR,   0, 4'b0110);
        step(MOVPC, 0, 4'h0);
        step(NOP,   0, 4'h0);
        step(NOP,   0, 4'h0);
        step(LDR,   0, 4'h0);
        step(NOP,   0, 4'h0);
        step(NOP,   0, 4'h0);
        pulse_reset("async_reset");
        for (int n = 0; n < 600; n++) begin
            step(rnd_instr(), $urandom_range(0, 7) == 0, 4'($urandom()));
            if (n == 300) pulse_reset("async_reset_rand");
        end
        step(NOP, 0, 4'h0);
        repeat (2) @(negedge CLK);
        checks++;
        if (sb0.size() + sb1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb0.size() + sb1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Pipelined control path for the ARMv3-subset core. Decodes the instruction in the Decode (D) stage and carries the control bits through the E, M and W pipeline registers.
- Holds the architectural NZCV flag register and evaluates the full ARM condition field in E.
- Gates every state-changing control bit with the condition result.
- Generalises the single-cycle decoder: wider ALU opcode space, conditional execution, flush support and early branch resolution.

Parameters:
- ALUCTRL_W, 2: width of the ALU control bus. 2 = ADD/SUB/AND/ORR only. 3 additionally enables EOR, MOV and CMP.
- EARLY_BRANCH, 1: 1 = a taken B is signalled in E via BranchTakenE. 0 = B resolves through PCSrcW like other PC writes.

Ports:
- CLK  in  1  core clock, rising edge
- RESETn  in  1  asynchronous active-low reset
- InstrD  in  32  instruction in Decode
- FlushE  in  1  from hazard unit: load a bubble into the E register on the next edge
- ALUFlagsE  in  4  NZCV produced by the ALU in E
- ImmSrcD  out  2  immediate extend select (combinational from InstrD)
- RegSrcD  out  2  register-file read-address select (combinational from InstrD)
- ALUSrcE  out  1  ALU operand B source: 1 = immediate
- ALUControlE  out  ALUCTRL_W  ALU operation select
- BranchTakenE  out  1  taken branch in E; always 0 when EARLY_BRANCH=0
- MemWriteM  out  1  data-memory write enable
- RegWriteM  out  1  register write in M, for forwarding
- MemtoRegE  out  1  load in E, for load-use hazard detection
- RegWriteW  out  1  register-file write enable
- MemtoRegW  out  1  result source: 1 = memory
- PCSrcW  out  1  PC written from the W result
- FlagsQ  out  4  current NZCV register

Behaviour:
- D decode, combinational from Op = InstrD[27:26].
  - Op 00: data processing. ImmSrc=00, RegSrc=00, ALUSrc=InstrD[25].
  - Op 01: LDR/STR, selected by InstrD[20]. ImmSrc=01, ALUSrc=1, ALU op = ADD. STR: RegSrc=10, MemW=1. LDR: RegW=1, MemtoReg=1.
  - Op 10: B. ImmSrc=10, RegSrc=01, ALU op = ADD, Branch=1.
  - Op 11: NOP, all enables 0.
- ALU op for DP, cmd = InstrD[24:21]:
  - 0100 ADD → 0, 0010 SUB → 1, 0000 AND → 2, 1100 ORR → 3.
  - When ALUCTRL_W ≥ 3 only: 0001 EOR → 4, 1101 MOV → 5, 1010 CMP → 1 with RegW forced 0 and flags always written.
  - Any other cmd, or an extended cmd when ALUCTRL_W=2, decodes as NOP: RegW=0, FlagW=00, ALU op 0.
- FlagWD for DP with S=InstrD[20]=1:
  - ADD, SUB, CMP: 11.
  - AND, ORR, EOR, MOV: 10.
  - Memory ops and B: 00.
- PCSD = (Rd==4'hF & RegW) | (Branch & ~EARLY_BRANCH).
- D→E register captures RegW, MemW, MemtoReg, ALUSrc, ALUControl, FlagW, Branch, PCS and Cond = InstrD[31:28].
  - FlushE=1 at an edge loads all-zero enables (a bubble). Cond in the bubble is don't-care because all enables are 0.
- Condition evaluation in E uses FlagsQ:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 0 (never).
- CondEx gates, in E:
  - RegWrite, MemWrite, PCS: bit & CondEx.
  - BranchTakenE = BranchE & CondEx & EARLY_BRANCH.
- Flag update at the clock edge ending E:
  - NZ ← ALUFlagsE[3:2] when FlagWE[1] & CondEx.
  - CV ← ALUFlagsE[1:0] when FlagWE[0] & CondEx.
  - An instruction in E evaluates against flags written by the instruction in E on the previous cycle. There is no extra latency.
- E→M register captures gated RegWrite, MemWrite, MemtoReg and PCS. M→W register captures RegWrite, MemtoReg and PCS.
- No stall input on E, M or W: these registers load every cycle.
- Reset (RESETn=0, asynchronous, any cycle): all pipeline registers and FlagsQ go to 0, so every registered output is 0. The first cycle after release contains only bubbles.
- D outputs are purely combinational and are unaffected by reset.

Test Plan:
- Reset with 0xE2811001 (ADD R1,R1,#1) in D → all registered outputs 0 and FlagsQ=0000 during reset. After release: ALUControlE=0 and ALUSrcE=1 one cycle later, RegWriteW=1 three cycles after the instruction enters D.
- SUBS (0xE0512002) with ALUFlagsE=0100 → FlagsQ=0100 on the next cycle. The following ADDEQ (0x02811001) has RegWriteM=1. ADDNE (0x12811001) instead has RegWriteM=0, MemWriteM=0, and FlagsQ is unchanged.
- BEQ (0x0A000002) in E with Z=1, EARLY_BRANCH=1 → BranchTakenE=1. Same instruction with Z=0 → BranchTakenE=0. With EARLY_BRANCH=0 → BranchTakenE stays 0 and PCSrcW=1 two cycles after E.
- FlushE=1 with STR (0xE5812000) in D → at the next edge the E stage holds a bubble: MemWriteM=0 one cycle later, RegWriteW=0 and PCSrcW=0 two cycles later.
- ALUCTRL_W=3: CMP (0xE1510002) gives ALUControlE=1, FlagsQ updated, RegWriteM=0. EOR (0xE0212003) gives ALUControlE=4. ALUCTRL_W=2: the same EOR gives RegWriteM=0.
- MOV PC with cond 1111 (0xF1A0F001) → PCSrcW=0. Pulse RESETn=0 mid-pipeline while a load is in M → MemtoRegW=0 and RegWriteW=0 immediately, asynchronously.
